// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, config register
// offsets inside the controller window, and the global-enable bit position.
// Pure package, no ports.
package irq_pkg;

  // FSM encoding, visible to software in STAT[1:0]
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  // Byte offsets within the window (memory map strips the base before us)
  localparam logic [31:0] REG_MASK = 32'h0000_0000;
  localparam logic [31:0] REG_PEND = 32'h0000_0004;
  localparam logic [31:0] REG_STAT = 32'h0000_0008;

  localparam int GLOBAL_EN_BIT = 31;

  // Window base used by the memory-map decode, not by this block
  localparam logic [31:0] IRQ_WINDOW_BASE = 32'h0070_0000;

endpackage

// File: rtl/irq_edge_latch.sv
// Rising-edge event capture into a pending vector with W1C and ack-clear.
// Latency: an edge sampled at posedge k shows in pending after edge k; no backpressure.
// Ports: clk/rst; irq_src levels; w1c_en/w1c_mask from PEND write; ack_clr/ack_idx
// from the FSM on handshake ack; pending out. A new event beats any clear of that bit.
module irq_edge_latch #(
  parameter int NUM_IRQ = 2,
  parameter int IW      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               w1c_en,
  input  logic [NUM_IRQ-1:0] w1c_mask,
  input  logic               ack_clr,
  input  logic [IW-1:0]      ack_idx,
  output logic [NUM_IRQ-1:0] pending
);

  logic [NUM_IRQ-1:0] prev_src;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;

  assign rise = irq_src & ~prev_src;

  always_comb begin
    clr = w1c_en ? w1c_mask : '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (ack_clr && (ack_idx == IW'(i))) clr[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_src <= '0;
      pending  <= '0;
    end else begin
      prev_src <= irq_src;
      // set is OR'd after the clear so a same-cycle event keeps the bit
      pending  <= (pending & ~clr) | rise;
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt scheduler: latch events, mask, fixed-priority pick, req/ack/done with pipeline.
// Latency: pending -> irq_req one cycle (IDLE consumes one cycle); ack -> SERVICE next edge.
// Backpressure: irq_req/irq_addr held until irq_ack; only one interrupt in service.
// Ports: clk/rst; irq_src events; cfg_addr/cfg_wrdata/cfg_we/cfg_rddata for MASK,
// PEND, STAT; irq_addr (zero-extended winner) to the IDT; irq_req/irq_ack/irq_done.
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic [31:0]        cfg_addr,
  input  logic [31:0]        cfg_wrdata,
  input  logic               cfg_we,
  output logic [31:0]        cfg_rddata,
  output logic [31:0]        irq_addr,
  output logic               irq_req,
  input  logic               irq_ack,
  input  logic               irq_done
);

  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  state_t             state_q, state_d;
  logic [IW-1:0]      cur_irq_q, cur_irq_d;
  logic [NUM_IRQ-1:0] mask_en;
  logic               global_en;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] elig;
  logic [IW-1:0]      winner;
  logic               ack_clr;
  logic               mask_wr;
  logic               pend_wr;
  logic               wrdata_unused;

  // Bits of write data outside the implemented fields are simply dropped
  assign wrdata_unused = ^cfg_wrdata;

  assign mask_wr = cfg_we && (cfg_addr == REG_MASK);
  assign pend_wr = cfg_we && (cfg_addr == REG_PEND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_en   <= '0;
      global_en <= 1'b0;
    end else if (mask_wr) begin
      mask_en   <= cfg_wrdata[NUM_IRQ-1:0];
      global_en <= cfg_wrdata[GLOBAL_EN_BIT];
    end
  end

  irq_edge_latch #(
    .NUM_IRQ (NUM_IRQ),
    .IW      (IW)
  ) u_edge_latch (
    .clk      (clk),
    .rst      (rst),
    .irq_src  (irq_src),
    .w1c_en   (pend_wr),
    .w1c_mask (cfg_wrdata[NUM_IRQ-1:0]),
    .ack_clr  (ack_clr),
    .ack_idx  (cur_irq_q),
    .pending  (pending)
  );

  // Mask register is read before its write lands, so a same-cycle
  // MASK write never affects this cycle's decision.
  assign elig = pending & mask_en & {NUM_IRQ{global_en}};

  // Lowest index wins: scan high to low so the last hit is the lowest
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) winner = IW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cur_irq_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_irq_q <= cur_irq_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_irq_d = cur_irq_q;
    ack_clr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (elig != '0) begin
          cur_irq_d = winner;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        // mask changes are deliberately ignored here: a raised request stays up
        if (irq_ack) begin
          ack_clr = 1'b1;
          state_d = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (irq_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decoded straight from state so reset drops the request immediately
  assign irq_req  = (state_q == S_REQ);
  assign irq_addr = 32'(cur_irq_q);

  always_comb begin
    cfg_rddata = '0;
    case (cfg_addr)
      REG_MASK: begin
        cfg_rddata[NUM_IRQ-1:0]    = mask_en;
        cfg_rddata[GLOBAL_EN_BIT]  = global_en;
      end
      REG_PEND: cfg_rddata[NUM_IRQ-1:0] = pending;
      REG_STAT: begin
        cfg_rddata[1:0]  = state_q;
        cfg_rddata[15:8] = 8'(cur_irq_q);
        cfg_rddata[16]   = irq_req;
      end
      default: cfg_rddata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: reset, priority, global enable, set-wins,
// mask change during request, and reset mid-handshake.
// Ports: none (top-level bench).
module tb_irq_controller;
  import irq_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  irq_src;
  logic [31:0] cfg_addr;
  logic [31:0] cfg_wrdata;
  logic        cfg_we;
  logic [31:0] cfg_rddata;
  logic [31:0] irq_addr;
  logic        irq_req;
  logic        irq_ack;
  logic        irq_done;

  int checks = 0;
  int errors = 0;
  logic [31:0] d;

  irq_controller #(.NUM_IRQ(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_src    (irq_src),
    .cfg_addr   (cfg_addr),
    .cfg_wrdata (cfg_wrdata),
    .cfg_we     (cfg_we),
    .cfg_rddata (cfg_rddata),
    .irq_addr   (irq_addr),
    .irq_req    (irq_req),
    .irq_ack    (irq_ack),
    .irq_done   (irq_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    cfg_addr = a;
    #1;
    v = cfg_rddata;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    cfg_addr   = a;
    cfg_wrdata = v;
    cfg_we     = 1'b1;
    tick();
    cfg_we     = 1'b0;
    cfg_wrdata = '0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic pulse_done();
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", irq_req); end
    checks++; if (irq_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", irq_addr); end
    rd(REG_MASK, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mask got %h want 0", d); end
    rd(REG_STAT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_stat got %h want 0", d); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    wr(REG_MASK, 32'h8000_0003);
    rd(REG_MASK, d);
    checks++; if (d !== 32'h8000_0003) begin errors++; $display("FAIL t1_mask got %h want 80000003", d); end
    irq_src = 2'b01;
    tick();
    irq_src = 2'b00;
    rd(REG_PEND, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL t1_pend got %h want 1", d); end
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL t1_req_early got %b want 0", irq_req); end
    tick();
    checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL t1_req got %b want 1", irq_req); end
    checks++; if (irq_addr !== 32'h0) begin errors++; $display("FAIL t1_addr got %h want 0", irq_addr); end
    rd(REG_STAT, d);
    checks++; if (d !== 32'h0001_0001) begin errors++; $display("FAIL t1_stat_req got %h want 00010001", d); end
    pulse_ack();
    rd(REG_PEND, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL t1_pend_ack got %h want 0", d); end
    rd(REG_STAT, d);
    checks++; if (d !== 32'h0000_0002) begin errors++; $display("FAIL t1_stat_svc got %h want 00000002", d); end
    pulse_done();
    rd(REG_STAT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL t1_stat_idle got %h want 0", d); end
  endtask

  task automatic test_priority();
    irq_src = 2'b11;
    tick();
    irq_src = 2'b00;
    tick();
    checks++; if (irq_req !== 1'b1 || irq_addr !== 32'h0) begin errors++; $display("FAIL t2_first got req=%b addr=%h want req=1 addr=0", irq_req, irq_addr); end
    pulse_ack();
    rd(REG_PEND, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL t2_pend got %h want 2", d); end
    pulse_done();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL t2_idle_gap got %b want 0", irq_req); end
    tick();
    checks++; if (irq_req !== 1'b1 || irq_addr !== 32'h1) begin errors++; $display("FAIL t2_second got req=%b addr=%h want req=1 addr=1", irq_req, irq_addr); end
    pulse_ack();
    pulse_done();
  endtask

  task automatic test_global_en_and_mask_change();
    wr(REG_MASK, 32'h0000_0003);
    irq_src = 2'b10;
    tick();
    irq_src = 2'b00;
    tick();
    tick();
    rd(REG_PEND, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL t3_pend got %h want 2", d); end
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL t3_req_off got %b want 0", irq_req); end
    wr(REG_MASK, 32'h8000_0003);
    // the decision at the write edge still used the old (disabled) mask
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL t3_old_mask got %b want 0", irq_req); end
    tick();
    checks++; if (irq_req !== 1'b1 || irq_addr !== 32'h1) begin errors++; $display("FAIL t3_req_on got req=%b addr=%h want req=1 addr=1", irq_req, irq_addr); end
    // now in REQ with irq_addr=1: mask off all sources, request must hold
    wr(REG_MASK, 32'h8000_0000);
    tick();
    checks++; if (irq_req !== 1'b1 || irq_addr !== 32'h1) begin errors++; $display("FAIL t5_hold got req=%b addr=%h want req=1 addr=1", irq_req, irq_addr); end
    pulse_done();
    rd(REG_STAT, d);
    checks++; if (d !== 32'h0001_0101) begin errors++; $display("FAIL t5_done_in_req got %h want 00010101", d); end
    pulse_ack();
    rd(REG_STAT, d);
    checks++; if (d !== 32'h0000_0102) begin errors++; $display("FAIL t5_svc got %h want 00000102", d); end
    pulse_ack();
    rd(REG_STAT, d);
    checks++; if (d !== 32'h0000_0102) begin errors++; $display("FAIL t5_ack_in_svc got %h want 00000102", d); end
    pulse_done();
    rd(REG_STAT, d);
    checks++; if (d !== 32'h0000_0100) begin errors++; $display("FAIL t5_idle got %h want 00000100", d); end
  endtask

  task automatic test_set_wins();
    wr(REG_MASK, 32'h0);
    irq_src = 2'b01;
    tick();
    irq_src = 2'b00;
    tick();
    // W1C of bit 0 and a fresh edge on bit 0 in the same cycle
    cfg_addr   = REG_PEND;
    cfg_wrdata = 32'h1;
    cfg_we     = 1'b1;
    irq_src    = 2'b01;
    tick();
    cfg_we     = 1'b0;
    irq_src    = 2'b00;
    rd(REG_PEND, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL t4_set_wins_w1c got %h want 1", d); end
    wr(REG_PEND, 32'h1);
    rd(REG_PEND, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL t4_w1c got %h want 0", d); end
    // ack-clear of bit 0 racing a new edge on bit 0
    wr(REG_MASK, 32'h8000_0001);
    irq_src = 2'b01;
    tick();
    irq_src = 2'b00;
    tick();
    checks++; if (irq_req !== 1'b1 || irq_addr !== 32'h0) begin errors++; $display("FAIL t4_req got req=%b addr=%h want req=1 addr=0", irq_req, irq_addr); end
    irq_ack = 1'b1;
    irq_src = 2'b01;
    tick();
    irq_ack = 1'b0;
    irq_src = 2'b00;
    rd(REG_PEND, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL t4_set_wins_ack got %h want 1", d); end
    pulse_done();
    tick();
    checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL t4_rereq got %b want 1", irq_req); end
    pulse_ack();
    pulse_done();
  endtask

  task automatic test_reset_mid_handshake();
    wr(REG_MASK, 32'h8000_0003);
    irq_src = 2'b10;
    tick();
    irq_src = 2'b00;
    tick();
    checks++; if (irq_req !== 1'b1 || irq_addr !== 32'h1) begin errors++; $display("FAIL t6_pre got req=%b addr=%h want req=1 addr=1", irq_req, irq_addr); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL t6_req got %b want 0", irq_req); end
    checks++; if (irq_addr !== 32'h0) begin errors++; $display("FAIL t6_addr got %h want 0", irq_addr); end
    tick();
    rst = 1'b0;
    tick();
    rd(REG_MASK, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL t6_mask got %h want 0", d); end
    rd(REG_PEND, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL t6_pend got %h want 0", d); end
    rd(REG_STAT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL t6_stat got %h want 0", d); end
  endtask

  initial begin
    rst        = 1'b1;
    irq_src    = 2'b00;
    cfg_addr   = '0;
    cfg_wrdata = '0;
    cfg_we     = 1'b0;
    irq_ack    = 1'b0;
    irq_done   = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_global_en_and_mask_change();
    test_set_wins();
    test_reset_mid_handshake();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
Interrupt scheduler that owns the IDT lookup path. It latches interrupt events from peripherals (keyboard, timer), applies a CPU-programmed mask, and selects one winner by fixed priority. It presents the winner's number on irq_addr to the IDT and runs a req/ack/done handshake with the pipeline, one interrupt in service at a time. Its config registers are mapped into the memory-map window at 32'h00700000; the memory map passes offsets already masked with ADDR_MASK.

Parameters:
NUM_IRQ, 2, number of interrupt sources; equals the IDT entry count; legal range 1..31.

Ports:
clk  in  1  system clock, all logic on posedge.
rst  in  1  asynchronous, active-high reset.
irq_src  in  NUM_IRQ  level inputs from peripherals, synchronous to clk; a rising edge is one event. Bit 0 is the highest priority.
cfg_addr  in  32  byte offset within the window; only 0x0, 0x4 and 0x8 are decoded.
cfg_wrdata  in  32  CPU write data.
cfg_we  in  1  CPU write strobe, already qualified by the window decode.
cfg_rddata  out  32  combinational read data for cfg_addr.
irq_addr  out  32  winning interrupt number, zero-extended; drives the IDT irq_addr input.
irq_req  out  1  interrupt request to the pipeline.
irq_ack  in  1  pipeline has taken the IDT handler address (single-cycle pulse).
irq_done  in  1  handler returned (single-cycle pulse).

Behaviour:
Registers:
- MASK at 0x0, read/write. Bits [NUM_IRQ-1:0] are per-source enables; bit 31 is the global enable; other bits read 0.
- PEND at 0x4. Reads return the pending bits. A write clears every pending bit where cfg_wrdata has a 1 (write-1-to-clear).
- STAT at 0x8, read-only. Bits [1:0] = state encoding; bits [15:8] = current irq number; bit 16 = irq_req.
- Other offsets read 0 and ignore writes.

Event capture:
- prev_src[i] is irq_src[i] registered.
- An event occurs when irq_src[i]=1 and prev_src[i]=0; pending[i] sets on that posedge.
- Events set pending even while the source is masked.

Eligibility and arbitration:
- elig = pending & MASK[NUM_IRQ-1:0], gated by MASK[31].
- The winner is the lowest set index in elig.

FSM (IDLE, REQ, SERVICE):
- IDLE: if elig != 0, latch the winner into cur_irq, set irq_req=1, go to REQ. Otherwise stay.
- REQ: hold irq_req and irq_addr stable until irq_ack is sampled high. On ack: clear pending[cur_irq], irq_req=0, go to SERVICE. A mask change during REQ does not withdraw the request.
- SERVICE: wait for irq_done, then go to IDLE. No nesting.
- An irq_done seen in IDLE or REQ is ignored. An irq_ack seen in IDLE or SERVICE is ignored.

Latency:
- irq_src first sampled high at edge k gives pending=1 after edge k.
- irq_req=1 after edge k+1, provided the FSM is in IDLE and the source is enabled.
- Back-to-back: irq_done at edge m, with another bit still eligible, gives irq_req=1 after edge m+1. IDLE consumes one cycle.

Simultaneous events:
- A new event on bit i wins over a W1C of bit i in the same cycle, and over the ack-clear of bit i in the same cycle; the bit stays set.
- A MASK write and an arbitration decision in the same cycle: the decision uses the old MASK.

Reset values (asynchronous, immediate):
- MASK=0, pending=0, prev_src=0, state=IDLE, cur_irq=0.
- irq_req=0, irq_addr=0.
- Reset mid-handshake drops irq_req immediately. The pipeline treats that as no interrupt.

Width rules:
- irq_addr = {zeros, cur_irq}.
- cur_irq is $clog2(NUM_IRQ) bits, minimum 1.

Decomposition:
- Package irq_pkg:
  - state encoding localparams S_IDLE=0, S_REQ=1, S_SERVICE=2;
  - register offsets REG_MASK=0x0, REG_PEND=0x4, REG_STAT=0x8;
  - GLOBAL_EN_BIT=31;
  - window base 32'h00700000, for the memory map decode.
- Sub-module irq_edge_latch holds prev_src, the pending vector, the W1C logic, the ack-clear logic and the set-wins priority. The FSM, arbiter and config decode stay in irq_controller.

Test Plan:
1. Reset, then MASK=0x80000003, then pulse irq_src=2'b01 -> PEND reads 0x1 one cycle later; irq_req=1 with irq_addr=0 the cycle after; ack -> PEND reads 0x0 and STAT[1:0]=2.
2. MASK=0x80000003, raise both sources in the same cycle -> irq_addr=0 first; after ack and done, irq_req rises again one cycle later with irq_addr=1.
3. MASK=0x00000003 (global enable off), event on bit 1 -> PEND=0x2 and irq_req stays 0; write MASK=0x80000003 -> irq_req=1, irq_addr=1.
4. Pending bit 0 set, write PEND=0x1 in the same cycle as a new rising edge on irq_src[0] -> PEND still reads 0x1.
5. In REQ with irq_addr=1, write MASK=0x80000000 -> irq_req stays 1 until ack; in SERVICE, pulse irq_ack -> no effect.
6. Assert rst while irq_req=1 -> irq_req=0 and irq_addr=0 immediately; MASK, PEND and STAT read 0 after release.
